// File: rtl/exec_unit_mc_if.sv
// Bundle between control and the multi-cycle execute stage: operands, ALU and
// multi-cycle controls in one direction, results, flags and the stall/done handshake back.
interface exec_unit_mc_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             alu_src;
    logic [3:0]       alu_op;
    logic             update_sreg;
    logic             result_sel;
    logic             mc_start;
    logic [1:0]       mc_mode;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             stall;
    logic             mc_done;

    modport master (
        output pc, imm, rd1, rd2, alu_src, alu_op, update_sreg, result_sel, mc_start, mc_mode,
        input  branch_target, result, negative, zero, carry, overflow, stall, mc_done
    );

    modport slave (
        input  pc, imm, rd1, rd2, alu_src, alu_op, update_sreg, result_sel, mc_start, mc_mode,
        output branch_target, result, negative, zero, carry, overflow, stall, mc_done
    );
endinterface

// File: rtl/exec_unit_mc.sv
// LEGv8 multi-cycle execute stage: branch adder, ALU with NZCV register and a shift-add multiplier.
// Defining EXEC_DIV_EN adds a restoring divider on mc_mode 11 (imm[10] selects signed).
module exec_unit_mc #(
    parameter int WIDTH    = 64,
    parameter int BR_SHIFT = 2,
    parameter int CNT_W    = 7
) (
    input  logic          clk,
    input  logic          reset,
    exec_unit_mc_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] MODE_MUL   = 2'b00;
    localparam logic [1:0] MODE_SMULH = 2'b01;
    localparam logic [1:0] MODE_DIV   = 2'b11;

    logic [WIDTH-1:0]   op_b;
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [SH_W-1:0]    shamt;
    logic [WIDTH-1:0]   alu_y;
    logic               alu_c;
    logic               alu_v;
    logic [3:0]         nzcv;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   res_q;
    logic [1:0]         mode_q;
    logic               neg_q;
    logic               start_ok;
    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_mul;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] fin;
    logic [WIDTH-1:0]   mc_final;
    logic [WIDTH-1:0]   mc_value;

    assign op_b              = bus.alu_src ? bus.imm : bus.rd2;
    assign bus.branch_target = bus.pc + (bus.imm << BR_SHIFT);

    assign add_full = {1'b0, bus.rd1} + {1'b0, op_b};
    assign sub_full = {1'b0, bus.rd1} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
    assign shamt    = op_b[SH_W-1:0];

    always_comb begin
        alu_y = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (bus.alu_op)
            4'b0000: alu_y = bus.rd1 & op_b;
            4'b0001: alu_y = bus.rd1 | op_b;
            4'b0010: begin
                alu_y = add_full[WIDTH-1:0];
                alu_c = add_full[WIDTH];
                alu_v = (bus.rd1[WIDTH-1] == op_b[WIDTH-1]) && (alu_y[WIDTH-1] != bus.rd1[WIDTH-1]);
            end
            4'b0011: alu_y = bus.rd1 ^ op_b;
            4'b0100: alu_y = bus.rd1 << shamt;
            4'b0101: alu_y = bus.rd1 >> shamt;
            4'b0110: begin
                alu_y = sub_full[WIDTH-1:0];
                alu_c = sub_full[WIDTH];
                alu_v = (bus.rd1[WIDTH-1] != op_b[WIDTH-1]) && (alu_y[WIDTH-1] != bus.rd1[WIDTH-1]);
            end
            4'b0111: alu_y = op_b;
            4'b1100: alu_y = ~(bus.rd1 | op_b);
            default: alu_y = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nzcv <= 4'b0000;
        end else if (bus.update_sreg) begin
            nzcv <= {alu_y[WIDTH-1], (alu_y == '0), alu_c, alu_v};
        end
    end

    assign bus.negative = nzcv[3];
    assign bus.zero     = nzcv[2];
    assign bus.carry    = nzcv[1];
    assign bus.overflow = nzcv[0];

`ifdef EXEC_DIV_EN
    // Narrow builds have no imm[10]; fall back to the top immediate bit.
    localparam int SGN_BIT = (WIDTH > 10) ? 10 : WIDTH - 1;

    logic               dz_q;
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_diff;
    logic [2*WIDTH-1:0] acc_div;

    assign start_ok  = bus.mc_start;
    assign op_signed = (bus.mc_mode == MODE_SMULH) || ((bus.mc_mode == MODE_DIV) && bus.imm[SGN_BIT]);

    assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign rem_ge   = rem_sh >= {1'b0, opnd};
    assign rem_diff = rem_sh[WIDTH-1:0] - opnd;
    assign acc_div  = rem_ge ? {rem_diff, acc[WIDTH-2:0], 1'b1}
                             : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    assign acc_step = (mode_q == MODE_DIV) ? acc_div : acc_mul;
`else
    assign start_ok  = bus.mc_start && (bus.mc_mode != MODE_DIV);
    assign op_signed = (bus.mc_mode == MODE_SMULH);
    assign acc_step  = acc_mul;
`endif

    assign a_neg = op_signed && bus.rd1[WIDTH-1];
    assign b_neg = op_signed && op_b[WIDTH-1];
    assign a_mag = a_neg ? -bus.rd1 : bus.rd1;
    assign b_mag = b_neg ? -op_b : op_b;

    // Upper half accumulates the multiplicand; the whole pair shifts right one bit per step.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign acc_mul = {mul_sum, acc[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            mode_q <= MODE_MUL;
            neg_q  <= 1'b0;
            res_q  <= '0;
`ifdef EXEC_DIV_EN
            dz_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state  <= RUN;
                        cnt    <= '0;
                        acc    <= {{WIDTH{1'b0}}, a_mag};
                        opnd   <= b_mag;
                        mode_q <= bus.mc_mode;
                        neg_q  <= a_neg ^ b_neg;
`ifdef EXEC_DIV_EN
                        dz_q   <= (op_b == '0);
`endif
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    res_q <= mc_final;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fin = neg_q ? -acc : acc;

    always_comb begin
        mc_final = fin[2*WIDTH-1:WIDTH];
        case (mode_q)
            MODE_MUL: mc_final = fin[WIDTH-1:0];
`ifdef EXEC_DIV_EN
            MODE_DIV: mc_final = dz_q ? '0 : fin[WIDTH-1:0];
`endif
            default:  mc_final = fin[2*WIDTH-1:WIDTH];
        endcase
    end

    // Bypass the result register during DONE so the value is visible alongside mc_done.
    assign mc_value    = (state == DONE) ? mc_final : res_q;
    assign bus.result  = bus.result_sel ? mc_value : alu_y;
    assign bus.stall   = reset && (((state == IDLE) && start_ok) || (state == RUN));
    assign bus.mc_done = (state == DONE);
endmodule

// File: doc/exec_unit_mc.md
Name: exec_unit_mc

Overview:
- Parametrised multi-cycle execute stage for the LEGv8 non-pipelined core; successor to the fixed 64-bit execute stage.
- Contains:
  - branch-target adder
  - single-cycle ALU with a 4-flag status register
  - iterative shift-add multiplier covering MUL/SMULH/UMULH
- Owns the stall/done handshake to control, so multi-cycle ops freeze PC and register-file writes until the result is ready.

Parameters:
- WIDTH, 64, datapath width in bits; legal range 8..64, must be even.
- BR_SHIFT, 2, left shift applied to the immediate for the branch target.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- pc  in  WIDTH  current instruction address.
- imm  in  WIDTH  sign-extended immediate.
- rd1  in  WIDTH  register operand A.
- rd2  in  WIDTH  register operand B.
- alu_src  in  1  1 = B operand is imm, 0 = B operand is rd2.
- alu_op  in  4  ALU function select.
- update_sreg  in  1  load NZCV from the ALU this cycle.
- result_sel  in  1  0 = ALU result, 1 = multi-cycle result.
- mc_start  in  1  start a multi-cycle op (level-sampled).
- mc_mode  in  2  00 MUL, 01 SMULH, 10 UMULH, 11 reserved (DIV when the option below is enabled).
- branch_target  out  WIDTH  pc + (imm << BR_SHIFT), modulo 2^WIDTH.
- result  out  WIDTH  selected result.
- negative, zero, carry, overflow  out  1 each  registered NZCV flags.
- stall  out  1  high while a multi-cycle op is pending.
- mc_done  out  1  one-cycle pulse when the multi-cycle result is valid.

Behaviour:
- branch_target: combinational.
- ALU: combinational on rd1 and operand B.
- alu_op encodings:
  - 0000 AND, 0001 ORR, 0010 ADD, 0011 EOR
  - 0100 LSL (B[5:0], masked to log2(WIDTH) bits), 0101 LSR
  - 0110 SUB, 0111 pass B, 1100 NOR
  - any other code yields 0.
- ALU flags:
  - N = result MSB; Z = result == 0.
  - C = carry out of ADD, or NOT borrow for SUB; 0 for logic/shift ops.
  - V = signed overflow on ADD/SUB; 0 otherwise.
- Status register:
  - loads on a rising edge when update_sreg = 1.
  - holds otherwise, including while stall is high.
  - reset value 0000.
- Multi-cycle FSM states: IDLE, RUN, DONE.
- IDLE:
  - mc_start = 1 latches rd1, operand B, mc_mode and counter = 0, then moves to RUN.
  - stall is driven combinationally high in that same cycle.
- RUN:
  - one multiplier bit per cycle, LSB first, into a 2*WIDTH accumulator.
  - SMULH: operands are converted to magnitude at latch time; the product sign is re-applied in DONE via two's-complement negation of the 2*WIDTH product.
  - stall = 1 throughout RUN.
  - after WIDTH cycles, moves to DONE.
- DONE (one cycle):
  - mc_done = 1, stall = 0.
  - result register: MUL takes product[WIDTH-1:0]; SMULH/UMULH take product[2W-1:W].
  - returns to IDLE.
- Latency: start seen in cycle 0, mc_done in cycle WIDTH+1; stall is high for cycles 0..WIDTH.
- mc_start while in RUN or DONE is ignored; control must re-issue it.
- mc_start in IDLE with mc_mode = 11 (option off): no state change, stall stays 0.
- Multi-cycle result register holds its value until the next DONE.
- result = mc result register when result_sel = 1, else ALU result.
- reset asserted at any time, including mid-RUN: FSM to IDLE; stall, mc_done, NZCV, accumulator and result register to 0. The aborted op is discarded.
- Reset values: stall 0, mc_done 0, NZCV 0. result and branch_target follow their combinational inputs.

Optional Feature:
- Macro EXEC_DIV_EN.
- Defined:
  - mc_mode 11 = divide by restoring division, one quotient bit per cycle, same RUN/DONE timing and latency WIDTH+1.
  - Signedness is selected by imm[10]: 1 = SDIV, 0 = UDIV.
  - Divide by zero gives quotient 0.
  - SDIV of most-negative by -1 gives most-negative.
  - Quotient is rounded toward zero.
- Undefined: mode 11 behaves as reserved (ignored), and no divider logic is synthesised.

Test Plan:
- ALU flags (WIDTH=64): rd1=0x7FFF_FFFF_FFFF_FFFF, rd2=1, ADD, update_sreg=1 -> result 0x8000_0000_0000_0000, NZCV=1001 after the edge. Then SUB 5-5 -> Z=1, C=1, N=0, V=0.
- Branch target: pc=0x1000, imm=-4 -> branch_target=0x0FF0. With imm=0x3FFF_FFFF_FFFF_FFFF -> wraps modulo 2^64.
- UMULH/MUL (WIDTH=16): 0xFFFF*0xFFFF, mode 10 -> mc_done at cycle 17, result 0xFFFE; stall high for cycles 0..16. Same operands with mode 00 -> 0x0001.
- SMULH (WIDTH=16): -3 * 5 -> result 0xFFFF. MUL -> 0xFFF1. A second mc_start during RUN is ignored and mc_done pulses exactly once.
- Reset mid-op: assert reset at cycle 5 of a MUL -> stall, mc_done and NZCV are 0 immediately. After release, a new MUL 7*6 returns 42.
- EXEC_DIV_EN: UDIV 100/7 -> 14; SDIV -100/7 -> -14; x/0 -> 0; SDIV 0x8000/-1 (WIDTH=16) -> 0x8000. With the option off, mode 11 leaves stall 0.
